// File: rtl/ftf_pkg.sv
// Fibonacci-numeral-system constants and sizing helpers for the FTF crosstalk-avoidance encoder.
package ftf_pkg;

  function automatic logic [63:0] fns(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd1;
    b = 64'd1;
    for (int j = 3; j <= k; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic logic [63:0] ftf_weight(input int i);
    return fns(i + 1);
  endfunction

  // Odd positions use the next Fibonacci number so a 1 never sits next to a forbidden pattern.
  function automatic logic [63:0] ftf_thresh(input int i);
    return (i % 2 == 0) ? fns(i + 1) : fns(i + 2);
  endfunction

  function automatic int ftf_data_w(input int code_w);
    logic [63:0] n;
    int w;
    n = fns(code_w + 1);
    w = 1;
    for (int j = 0; j < 64; j++)
      if ((64'd1 << j) < n) w = j + 1;
    return w;
  endfunction

  function automatic int ftf_stages(input int code_w, input int bits_per_stg);
    return (code_w - 1 + bits_per_stg - 1) / bits_per_stg;
  endfunction

endpackage

// File: rtl/ftf_enc_stage.sv
// One pipeline stage: greedy MSB-first FNS digit slice plus its valid/ready-gated register.
module ftf_enc_stage
  import ftf_pkg::*;
#(
  parameter int CODE_W  = 29,
  parameter int DATA_W  = 20,
  parameter int TOP_BIT = 28,
  parameter int NBITS   = 7,
  parameter bit LAST    = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              next_en,
  input  logic              prev_valid,
  input  logic [CODE_W-1:0] prev_code,
  input  logic [DATA_W-1:0] prev_rem,
  input  logic              prev_err,
  output logic              en,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] rem,
  output logic              err
);

  logic [DATA_W-1:0] r_c [NBITS+1];
  logic [NBITS-1:0]  bits;
  logic [CODE_W-1:0] code_n;

  assign r_c[0] = prev_rem;

  for (genvar k = 0; k < NBITS; k++) begin : g_bit
    localparam logic [DATA_W-1:0] W = DATA_W'(ftf_weight(TOP_BIT - k));
    localparam logic [DATA_W-1:0] T = DATA_W'(ftf_thresh(TOP_BIT - k));
    assign bits[NBITS-1-k] = (r_c[k] >= T);
    assign r_c[k+1]        = bits[NBITS-1-k] ? (r_c[k] - W) : r_c[k];
  end

  always_comb begin
    code_n                   = prev_code;
    code_n[TOP_BIT -: NBITS] = bits;
    if (LAST) code_n[0] = r_c[NBITS][0];
    // Out-of-range words leave the pipe as an all-zero code.
    if (prev_err) code_n = '0;
  end

  assign en = !valid | next_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      code  <= '0;
      rem   <= '0;
      err   <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
      code  <= code_n;
      rem   <= r_c[NBITS];
      err   <= prev_err;
    end
  end

endmodule

// File: rtl/ftf_encoder_pipe.sv
// Pipelined FNS forbidden-transition-free encoder, one word per cycle, valid/ready on both sides.
// Build option RANGE_CHECK_EN: flag inputs >= FNS(CODE_W+1) and emit them as out_err=1, out_code=0.
module ftf_encoder_pipe
  import ftf_pkg::*;
#(
  parameter  int CODE_W       = 29,
  parameter  int BITS_PER_STG = 7,
  localparam int DATA_W       = ftf_data_w(CODE_W),
  localparam int STAGES       = ftf_stages(CODE_W, BITS_PER_STG)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err
);

  localparam logic [63:0] LIMIT = fns(CODE_W + 1);

  logic              valid_s [STAGES+1];
  logic [CODE_W-1:0] code_s  [STAGES+1];
  logic [DATA_W-1:0] rem_s   [STAGES+1];
  logic              err_s   [STAGES+1];
  logic              en_s    [STAGES+1];

  assign valid_s[0]  = in_valid;
  assign code_s[0]   = '0;
  assign rem_s[0]    = in_data;
  assign en_s[STAGES] = out_ready;

`ifdef RANGE_CHECK_EN
  assign err_s[0] = (64'(in_data) >= LIMIT);
`else
  assign err_s[0] = 1'b0;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int TOP = CODE_W - 1 - s * BITS_PER_STG;
    localparam int LOW = (CODE_W - (s + 1) * BITS_PER_STG > 1) ?
                         (CODE_W - (s + 1) * BITS_PER_STG) : 1;
    ftf_enc_stage #(
      .CODE_W (CODE_W),
      .DATA_W (DATA_W),
      .TOP_BIT(TOP),
      .NBITS  (TOP - LOW + 1),
      .LAST   (s == STAGES - 1)
    ) u_stg (
      .clock     (clock),
      .reset_n   (reset_n),
      .next_en   (en_s[s+1]),
      .prev_valid(valid_s[s]),
      .prev_code (code_s[s]),
      .prev_rem  (rem_s[s]),
      .prev_err  (err_s[s]),
      .en        (en_s[s]),
      .valid     (valid_s[s+1]),
      .code      (code_s[s+1]),
      .rem       (rem_s[s+1]),
      .err       (err_s[s+1])
    );
  end

  // Hold off the source while reset is asserted even though the stages read as empty.
  assign in_ready  = en_s[0] & reset_n;
  assign out_valid = valid_s[STAGES];
  assign out_code  = code_s[STAGES];
  assign out_err   = err_s[STAGES];

endmodule

// File: tb/tb_ftf_encoder_pipe.sv
// Bench for ftf_encoder_pipe: default build plus a CODE_W=5 instance, reference model and scoreboard.
module tb_ftf_encoder_pipe;

  localparam int CW = 29;
  localparam int DW = 20;
  localparam int ST = 4;
  localparam logic [63:0] LIM = 64'd832040;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] out_code;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_err;

  logic [2:0] in5_data = '0;
  logic       in5_valid = 1'b0;
  logic       in5_ready;
  logic [4:0] out5_code;
  logic       out5_valid;
  logic       out5_ready = 1'b1;
  logic       out5_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ftf_encoder_pipe dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_err(out_err)
  );

  ftf_encoder_pipe #(.CODE_W(5), .BITS_PER_STG(2)) dut5 (
    .clock(clock), .reset_n(reset_n), .in_data(in5_data), .in_valid(in5_valid),
    .in_ready(in5_ready), .out_code(out5_code), .out_valid(out5_valid),
    .out_ready(out5_ready), .out_err(out5_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] fib(input int k);
    logic [63:0] f [0:63];
    f[1] = 1; f[2] = 1;
    for (int j = 3; j <= k; j++) f[j] = f[j-1] + f[j-2];
    return f[k];
  endfunction

  function automatic logic [63:0] enc_m(input int cw, input logic [63:0] v);
    logic [63:0] r, c, th;
    r = v; c = 0;
    for (int i = cw - 1; i >= 1; i--) begin
      th = (i % 2 == 0) ? fib(i + 1) : fib(i + 2);
      if (r >= th) begin
        c[i] = 1'b1;
        r = r - fib(i + 1);
      end
    end
    c[0] = r[0];
    return c;
  endfunction

  typedef struct {
    logic [63:0] code;
    logic        err;
    bit          chk;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  bit   lat_chk = 0;
  bit   stall_probe = 0;
  int   rmode = 0;
  int   stream_start = 0;

  // out_ready pattern generator
  initial forever begin
    @(posedge clock); #1;
    case (rmode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = !((cyc - stream_start) >= 6 && (cyc - stream_start) <= 10);
      default: out_ready = 1'b1;
    endcase
  end

  // compare process
  initial begin
    bit stalled = 0;
    logic [CW-1:0] hold_code;
    logic hold_err;
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_code", 64'(out_code), 64'(hold_code));
          check("stall_err", 64'(out_err), 64'(hold_err));
        end
        if (stall_probe && !out_ready) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_buffered", 64'(sb.size()), 64'(ST));
          stall_probe = 0;
        end
        if (in_valid && in_ready) begin
          e.acc = cyc;
`ifdef RANGE_CHECK_EN
          e.err  = (64'(in_data) >= LIM);
          e.code = e.err ? 64'd0 : enc_m(CW, 64'(in_data));
          e.chk  = 1;
`else
          e.err  = 1'b0;
          e.code = enc_m(CW, 64'(in_data));
          e.chk  = (64'(in_data) < LIM);
`endif
          sb.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL spurious_word: got code %0h, required no word", out_code);
          end else begin
            e = sb.pop_front();
            check("out_err", 64'(out_err), 64'(e.err));
            if (e.chk) check("out_code", 64'(out_code), e.code);
            if (lat_chk) check("latency", 64'(cyc - e.acc), 64'(ST));
          end
        end
        stalled   = out_valid && !out_ready;
        hold_code = out_code;
        hold_err  = out_err;
      end
    end
  end

  // starts and ends at posedge+1
  task automatic send(input logic [DW-1:0] d, input int idle_pct);
    bit acc;
    int guard;
    if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
      in_valid = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    acc = 0;
    while (!acc && guard < 200) begin
      #1 acc = in_ready;
      @(posedge clock); #1;
      guard++;
    end
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 for 200 cycles, required 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [4:0] tbl5 [8];

  initial begin
    tbl5[0] = 5'b00000; tbl5[1] = 5'b00001; tbl5[2] = 5'b00100; tbl5[3] = 5'b00101;
    tbl5[4] = 5'b00111; tbl5[5] = 5'b10000; tbl5[6] = 5'b10001; tbl5[7] = 5'b10100;

    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_code", 64'(out_code), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // pin the model with hand-derived codes
    check("model_0", enc_m(CW, 64'd0), 64'd0);
    check("model_514229", enc_m(CW, 64'd514229), 64'h1000_0000);
    check("model_832039", enc_m(CW, 64'd832039), 64'h1555_5554);
    for (int k = 0; k < 8; k++) check("model5", enc_m(5, 64'(k)), 64'(tbl5[k]));

    // CODE_W=5 instance: 0..7 back to back, latency 2
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      in5_valid = (c < 8);
      in5_data  = 3'(c);
      @(negedge clock);
      if (c == 0) check("cw5_in_ready", 64'(in5_ready), 64'd1);
      check("cw5_valid", 64'(out5_valid), 64'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) check("cw5_code", 64'(out5_code), 64'(tbl5[c-2]));
      check("cw5_err", 64'(out5_err), 64'd0);
    end
    in5_valid = 1'b0;
    @(posedge clock); #1;

    // directed default-size words with exact latency
    lat_chk = 1;
    send(20'd0, 0);
    send(20'd514229, 0);
    send(20'd832039, 0);
    drain();
    lat_chk = 0;

    // stream with a 5-cycle sink stall
    stream_start = cyc;
    stall_probe = 1;
    rmode = 2;
    for (int k = 0; k < 20; k++) send(DW'($urandom_range(0, 832039)), 0);
    drain();
    rmode = 0;
    if (stall_probe) begin
      n_vec++; n_bad++;
      $display("FAIL stall_probe: got no stalled cycle, required one");
      stall_probe = 0;
    end

    // random valid and ready
    rmode = 1;
    for (int k = 0; k < 1000; k++) send(DW'($urandom_range(0, 832039)), 30);
    drain();
    rmode = 0;

    // out-of-range words around the legal boundary
    send(20'd832040, 0);
    send(20'd100, 0);
    send(20'hFFFFF, 0);
    send(20'd832039, 0);
    drain();

    // asynchronous reset mid-stream
    for (int k = 0; k < 6; k++) send(DW'(1000 + k), 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    #10;
    reset_n = 1'b1;
    #1;
    check("post_rst_empty", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    lat_chk = 1;
    send(20'd514229, 0);
    drain();
    lat_chk = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
